// File: rtl/arm_pipeline_defs.sv
// Shared fetch/decode pipeline definitions: default word width, bubble encoding,
// layout of a buffered {PC+4, instruction} entry and the buffer occupancy states.
package arm_pipeline_defs;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam logic [31:0] NOP_INSTRUCTION    = 32'h0;

    // Entry layout for the default width: PC+4 in the upper word, instruction in the lower
    localparam int unsigned ENTRY_PC_MSB    = 2 * DEFAULT_DATA_WIDTH - 1;
    localparam int unsigned ENTRY_PC_LSB    = DEFAULT_DATA_WIDTH;
    localparam int unsigned ENTRY_INSTR_MSB = DEFAULT_DATA_WIDTH - 1;
    localparam int unsigned ENTRY_INSTR_LSB = 0;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_state_e;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/occupancy controller for the IF/ID buffer: flush beats push/pop,
// a full buffer refuses a push even when a pop happens in the same cycle.
module fifo_ptr_ctrl
    import arm_pipeline_defs::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_req,
    input  logic                 pop_req,
    input  logic                 flush,
    output logic [PTR_WIDTH-1:0] wr_ptr,
    output logic [PTR_WIDTH-1:0] rd_ptr,
    output logic [PTR_WIDTH:0]   count,
    output logic                 push_en,
    output logic                 pop_en,
    output logic                 full,
    output logic                 empty
);

    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH:0]   CNT_FULL = (PTR_WIDTH + 1)'(DEPTH);

    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]   count_q, count_d;
    occ_state_e           occ;

    always_comb begin
        occ = OCC_PARTIAL;
        if (count_q == '0) begin
            occ = OCC_EMPTY;
        end else if (count_q == CNT_FULL) begin
            occ = OCC_FULL;
        end
    end

    assign full    = (occ == OCC_FULL);
    assign empty   = (occ == OCC_EMPTY);
    assign push_en = push_req && !full && !flush;
    assign pop_en  = pop_req && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO: queues {PC+4, instruction} from fetch, presents the oldest to decode.
// Optional stall/flush statistics counters under `IF_ID_BUFFER_STATS_EN.
module if_id_buffer
    import arm_pipeline_defs::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_Pc,
    input  logic [DATA_WIDTH-1:0] i_Instruction,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic                  i_Flush,
    output logic [DATA_WIDTH-1:0] o_Pc,
    output logic [DATA_WIDTH-1:0] o_Instruction,
    output logic                  o_Valid,
    input  logic                  i_Ready,
    output logic [PTR_WIDTH:0]    o_Count
`ifdef IF_ID_BUFFER_STATS_EN
   ,output logic [15:0]           o_Stall_Cycles,
    output logic [15:0]           o_Flush_Count
`endif
);

    logic [PTR_WIDTH-1:0]    wr_ptr, rd_ptr;
    logic [PTR_WIDTH:0]      count;
    logic                    push_en, pop_en, full, empty;
    logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [2*DATA_WIDTH-1:0] head_entry;

    fifo_ptr_ctrl #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_ptr_ctrl (
        .clk      (clk),
        .reset    (reset),
        .push_req (i_Valid),
        .pop_req  (i_Ready),
        .flush    (i_Flush),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .push_en  (push_en),
        .pop_en   (pop_en),
        .full     (full),
        .empty    (empty)
    );

    // Storage is not reset; an empty buffer never exposes it
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr] <= {i_Pc, i_Instruction};
        end
    end

    assign head_entry = mem_q[rd_ptr];

    always_comb begin
        o_Pc          = '0;
        o_Instruction = DATA_WIDTH'(NOP_INSTRUCTION);
        if (!empty) begin
            o_Pc          = head_entry[2*DATA_WIDTH-1 -: DATA_WIDTH];
            o_Instruction = head_entry[DATA_WIDTH-1:0];
        end
    end

    assign o_Valid = !empty;
    assign o_Ready = !full;
    assign o_Count = count;

`ifdef IF_ID_BUFFER_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_d     = stall_q;
        flush_cnt_d = flush_cnt_q;
        if (!empty && !i_Ready && !i_Flush && (stall_q != '1)) begin
            stall_d = stall_q + 16'd1;
        end
        if (i_Flush && !empty && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_q     <= stall_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_Stall_Cycles = stall_q;
    assign o_Flush_Count  = flush_cnt_q;
`endif

    logic unused_pop;
    assign unused_pop = pop_en;

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: the driver queues expected head entries,
// a negedge monitor pops and compares them whenever decode consumes the head.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_Pc, i_Instruction;
    logic        i_Valid, i_Ready, i_Flush;
    logic        o_Ready, o_Valid;
    logic [31:0] o_Pc, o_Instruction;
    logic [2:0]  o_Count;
`ifdef IF_ID_BUFFER_STATS_EN
    logic [15:0] o_Stall_Cycles, o_Flush_Count;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          model_cnt = 0;
    bit          mon_en   = 1'b0;
    logic [63:0] sb [$];

    always #5 clk = ~clk;

    if_id_buffer #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .PTR_WIDTH  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_Pc          (i_Pc),
        .i_Instruction (i_Instruction),
        .i_Valid       (i_Valid),
        .o_Ready       (o_Ready),
        .i_Flush       (i_Flush),
        .o_Pc          (o_Pc),
        .o_Instruction (o_Instruction),
        .o_Valid       (o_Valid),
        .i_Ready       (i_Ready),
        .o_Count       (o_Count)
`ifdef IF_ID_BUFFER_STATS_EN
       ,.o_Stall_Cycles (o_Stall_Cycles),
        .o_Flush_Count  (o_Flush_Count)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the occupancy model follows the buffer rules independently
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic r, input logic f);
        logic push, pop;
        i_Valid       = v;
        i_Pc          = pc;
        i_Instruction = ins;
        i_Ready       = r;
        i_Flush       = f;
        push = v && (model_cnt != 4) && !f;
        pop  = r && (model_cnt != 0) && !f;
        if (f) sb.delete();
        if (push) sb.push_back({pc, ins});
        @(posedge clk);
        if (f) model_cnt = 0;
        else   model_cnt = model_cnt + int'(push) - int'(pop);
        #1;
    endtask

    // Monitor: status flags every cycle, head entry whenever it is consumed
    initial begin
        logic [63:0] exp_entry;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("count", 64'(o_Count), 64'(model_cnt));
                chk("o_Valid", 64'(o_Valid), 64'(model_cnt != 0));
                chk("o_Ready", 64'(o_Ready), 64'(model_cnt != 4));
                if (model_cnt == 0) begin
                    chk("bubble_out", {o_Pc, o_Instruction}, 64'h0);
                end
                if (o_Valid && i_Ready && !i_Flush) begin
                    if (sb.size() == 0) begin
                        chk("sb_underrun", 64'(1), 64'(0));
                    end else begin
                        exp_entry = sb.pop_front();
                        chk("head_entry", {o_Pc, o_Instruction}, exp_entry);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        i_Valid = 0; i_Ready = 0; i_Flush = 0; i_Pc = '0; i_Instruction = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Stall/flush statistics: one push, 5 stalled cycles, one flush
        step(1, 32'h40, 32'hE3A0000F, 0, 0);
        for (int unsigned i = 0; i < 5; i++) step(0, 32'h0, 32'h0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 1);
`ifdef IF_ID_BUFFER_STATS_EN
        chk("stall_cycles", 64'(o_Stall_Cycles), 64'd5);
        chk("flush_count", 64'(o_Flush_Count), 64'd1);
`endif

        // Fill, refuse a fifth push, drain in order
        step(1, 32'd4,  32'hE3A00001, 0, 0);
        step(1, 32'd8,  32'hE3A01002, 0, 0);
        step(1, 32'd12, 32'hE2800001, 0, 0);
        step(1, 32'd16, 32'hE1A00000, 0, 0);
        step(1, 32'd20, 32'hDEADBEEF, 0, 0);
        for (int unsigned i = 0; i < 5; i++) step(0, 32'h0, 32'h0, 1, 0);

        // Streaming with pointer wrap: occupancy holds at 1
        for (int unsigned i = 1; i <= 10; i++) begin
            step(1, 32'(4 * i), 32'hE2800000 + 32'(i), 1, 0);
        end
        step(0, 32'h0, 32'h0, 1, 0);

        // Full plus simultaneous pop: push refused, next cycle accepted
        step(1, 32'h20, 32'hA0000001, 0, 0);
        step(1, 32'h24, 32'hA0000002, 0, 0);
        step(1, 32'h28, 32'hA0000003, 0, 0);
        step(1, 32'h2C, 32'hA0000004, 0, 0);
        step(1, 32'h30, 32'hA0000005, 1, 0);
        step(1, 32'h30, 32'hA0000005, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Flush with count=3 overrides push and pop, then a fresh push falls through
        step(1, 32'h34, 32'hA0000006, 1, 1);
        step(1, 32'h100, 32'hEA000000, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Asynchronous reset mid-cycle with entries present
        step(1, 32'h200, 32'hE3A0F000, 0, 0);
        step(1, 32'h204, 32'hE3A0F001, 0, 0);
        mon_en = 1'b0;
        i_Valid = 0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_valid", 64'(o_Valid), 64'd0);
        chk("rst_ready", 64'(o_Ready), 64'd1);
        chk("rst_count", 64'(o_Count), 64'd0);
        chk("rst_pc", 64'(o_Pc), 64'd0);
        chk("rst_instr", 64'(o_Instruction), 64'd0);
`ifdef IF_ID_BUFFER_STATS_EN
        chk("rst_stall", 64'(o_Stall_Cycles), 64'd0);
`endif
        sb.delete();
        model_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step(1, 32'h300, 32'hE1A0F00E, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        @(negedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Decoupling buffer between the fetch stage and the decode stage.
- Captures the {PC+4, instruction} pair that fetch produces each cycle into a small circular FIFO and presents the oldest entry to decode.
- Its `o_Ready` drives the fetch-stage freeze input: freeze = ~o_Ready.
- `i_Flush` discards all queued fetches when a branch is taken.

Parameters:
- DATA_WIDTH, 32, width of PC and instruction words
- DEPTH, 4, number of entries; power of two, >= 2
- PTR_WIDTH, 2, log2(DEPTH); pointer width

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- i_Pc  input  DATA_WIDTH  PC+4 from fetch stage
- i_Instruction  input  DATA_WIDTH  instruction word from fetch stage
- i_Valid  input  1  fetch presents a valid pair this cycle
- o_Ready  output  1  buffer can accept a push (not full)
- i_Flush  input  1  branch taken; discard all entries
- o_Pc  output  DATA_WIDTH  head-entry PC+4 to decode
- o_Instruction  output  DATA_WIDTH  head-entry instruction to decode
- o_Valid  output  1  head entry valid
- i_Ready  input  1  decode consumes head this cycle (~hazard freeze)
- o_Count  output  PTR_WIDTH+1  current occupancy

Behaviour:
- Reset (async, active-high):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - o_Valid = 0, o_Ready = 1.
  - o_Pc = 0, o_Instruction = 0.
  - Storage contents are don't-care.
- Push condition: i_Valid && o_Ready && !i_Flush.
  - Writes mem[wr_ptr] = {i_Pc, i_Instruction}.
  - wr_ptr increments modulo DEPTH (natural wrap at PTR_WIDTH bits).
- Pop condition: o_Valid && i_Ready && !i_Flush.
  - rd_ptr increments modulo DEPTH.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Status flags:
  - o_Ready = (count != DEPTH). Depends on registered count only; no combinational path from i_Ready.
  - Full buffer refuses a push even when a pop occurs in the same cycle.
  - o_Valid = (count != 0).
- Head outputs:
  - o_Pc / o_Instruction = mem[rd_ptr] when o_Valid, else all zeros. Zero instruction acts as a bubble to decode.
  - Outputs are combinational from registered state.
- Latency:
  - A push at edge N is visible on the outputs after edge N if the buffer was empty (1-cycle fall-through).
  - Otherwise FIFO order is preserved.
- Flush:
  - Highest priority: wr_ptr = rd_ptr = 0, count = 0 on the next edge.
  - A simultaneous push and pop are both ignored.
  - o_Valid = 0 the cycle after.
- Boundaries:
  - Empty: a pop request is ignored and count never underflows.
  - Full: a push request is ignored and count never exceeds DEPTH.
  - Pointer wrap DEPTH-1 -> 0 is seamless.
- Reset asserted mid-operation clears state immediately, regardless of clk.
- No internal FSM beyond the count/pointer state. Occupancy states are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH), with transitions as given by the count rules above.

Optional Feature:
- Macro: IF_ID_BUFFER_STATS_EN
- Defined:
  - Adds output port o_Stall_Cycles [15:0].
  - Counter increments every cycle where o_Valid && !i_Ready && !i_Flush.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
  - Adds output o_Flush_Count [15:0], saturating, incremented on each cycle where i_Flush=1 and count!=0.
- Undefined: ports and counters absent; remaining behaviour identical.

Decomposition:
- Shared package/header `arm_pipeline_defs`:
  - DATA_WIDTH default.
  - NOP_INSTRUCTION constant (32'h0).
  - Entry field offsets: PC in [2*DATA_WIDTH-1:DATA_WIDTH], instruction in [DATA_WIDTH-1:0].
- One sub-module is natural: `fifo_ptr_ctrl`.
  - Holds wr_ptr, rd_ptr and count.
  - Applies the flush, push and pop priority rules.
  - Produces the full/empty flags.
- The top level holds the storage array and the output muxing.

Test Plan:
- Reset: hold reset=1 mid-clock with entries present -> o_Valid=0, o_Ready=1, o_Count=0, o_Pc=0, o_Instruction=0 immediately.
- Fill and drain: i_Ready=0, push pairs {4,0xE3A00001}, {8,0xE3A01002}, {12,0xE2800001}, {16,0xE1A00000} -> o_Ready=0 and o_Count=4. A fifth push is ignored. With i_Ready=1 the pairs emerge in order over 4 cycles, then o_Valid=0 with outputs zero.
- Streaming: i_Valid=1 and i_Ready=1 continuously with PC 4,8,12,… -> o_Count stays 1 and o_Pc lags i_Pc by one cycle. Run 10 pushes to exercise pointer wrap.
- Full plus simultaneous pop: count=4, i_Valid=1, i_Ready=1 -> push rejected, head popped, count=3. The next cycle accepts the push.
- Flush: count=3, i_Flush=1 with i_Valid=1 and i_Ready=1 -> next cycle count=0, o_Valid=0. After that, push {0x100, 0xEA000000} appears at head one edge later.
- Stats (IF_ID_BUFFER_STATS_EN): hold o_Valid=1 with i_Ready=0 for 5 cycles, then flush once -> o_Stall_Cycles=5, o_Flush_Count=1.
